// File: rtl/gpio_pads_ctrl_pgen.sv
// Serial configuration engine for the GPIO pad daisy chain.
// Shifts CFG_WIDTH*(pad_no+1) bits MSB-first with programmable phase length,
// then pulses the load strobe (write/broadcast) and reports done/error.
//
// Request handshake: shift_req is a level; it is taken only while the engine
// is idle (busy=0). mode, pad number and data are latched on the accepting
// edge. shift_done marks the end of every accepted request; a rejected
// request (pad out of range or reserved mode) gets shift_done+shift_err one
// cycle later and never touches the pad pins.
module gpio_pads_ctrl_pgen #(
    parameter int CFG_WIDTH = 16,
    parameter int NUM_PADS  = 64,
    parameter int PW        = 8,
    parameter int HALF_PER  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 shift_req,
    input  logic [1:0]           cfg_mode,
    input  logic [PW-1:0]        cfg_pad_no,
    input  logic [CFG_WIDTH-1:0] cfg_shift_data,
    output logic                 busy,
    output logic                 shift_done,
    output logic                 shift_err,
    output logic [CFG_WIDTH-1:0] capture_data,
    output logic                 shift_rstn,
    output logic                 shift_clock,
    output logic                 shift_load,
    output logic                 shift_data_out,
    input  logic                 shift_data_in
);

    localparam int CW = $clog2(CFG_WIDTH * NUM_PADS) + 1;
    localparam int HW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
    localparam int WW = $clog2(CFG_WIDTH);

    localparam logic [HW-1:0] PH_LAST = HW'(HALF_PER - 1);
    localparam logic [WW-1:0] W_LAST  = WW'(CFG_WIDTH - 1);

    localparam logic [1:0] MODE_BCAST = 2'd1;
    localparam logic [1:0] MODE_SHIFT = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RST_HOLD = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
    localparam logic [2:0] S_SETUP    = 3'd3;
    localparam logic [2:0] S_CLK_HI   = 3'd4;
    localparam logic [2:0] S_CLK_LO   = 3'd5;
    localparam logic [2:0] S_LOAD     = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    logic [2:0]           state_q;
    logic [2:0]           state_d;
    logic [HW-1:0]        ph_q;
    logic [1:0]           mode_q;
    logic [CFG_WIDTH-1:0] word_q;
    logic [CFG_WIDTH-1:0] sreg_q;
    logic [WW-1:0]        widx_q;
    logic [CW-1:0]        bit_cnt_q;
    logic [CW-1:0]        n_total_q;
    logic [CW-1:0]        n_calc;
    logic                 req_bad;
    logic                 accept;
    logic                 reject;
    logic                 ph_last;
    logic                 bits_done;

    assign req_bad   = (32'(cfg_pad_no) >= 32'(NUM_PADS)) || (cfg_mode == MODE_RSVD);
    assign accept    = (state_q == S_IDLE) && shift_req && !req_bad;
    assign reject    = (state_q == S_IDLE) && shift_req && req_bad;
    assign ph_last   = (ph_q == PH_LAST);
    assign bits_done = (bit_cnt_q == n_total_q);
    // Only evaluated for in-range pads, so the product always fits in CW bits.
    assign n_calc    = CW'(CFG_WIDTH) * (CW'(cfg_pad_no) + CW'(1));

    // Next-state decode: each timed phase lasts HALF_PER cycles, DATA one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (shift_req) state_d = req_bad ? S_DONE : S_RST_HOLD;
            S_RST_HOLD: if (ph_last) state_d = S_DATA;
            S_DATA:     state_d = S_SETUP;
            S_SETUP:    if (ph_last) state_d = S_CLK_HI;
            S_CLK_HI:   if (ph_last) state_d = S_CLK_LO;
            S_CLK_LO: begin
                if (ph_last) begin
                    if (!bits_done)               state_d = S_DATA;
                    else if (mode_q == MODE_SHIFT) state_d = S_DONE;
                    else                           state_d = S_LOAD;
                end
            end
            S_LOAD:     if (ph_last) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // State register and phase timer; the timer restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) ph_q <= '0;
            else                    ph_q <= ph_q + 1'b1;
        end
    end

    // Pad pins and status flags registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            shift_done  <= 1'b0;
            shift_err   <= 1'b0;
            shift_clock <= 1'b0;
            shift_load  <= 1'b0;
        end else begin
            busy        <= (state_d != S_IDLE) && ((state_d != S_DONE) || reject);
            shift_done  <= (state_d == S_DONE);
            shift_err   <= reject;
            shift_clock <= (state_d == S_CLK_HI);
            shift_load  <= (state_d == S_LOAD);
        end
    end

    // Request latch, serial data path, bit counting and capture of the return stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q         <= '0;
            word_q         <= '0;
            sreg_q         <= '0;
            widx_q         <= '0;
            bit_cnt_q      <= '0;
            n_total_q      <= '0;
            shift_rstn     <= 1'b0;
            shift_data_out <= 1'b0;
            capture_data   <= '0;
        end else begin
            if (accept) begin
                mode_q     <= cfg_mode;
                word_q     <= cfg_shift_data;
                sreg_q     <= cfg_shift_data;
                widx_q     <= '0;
                bit_cnt_q  <= '0;
                n_total_q  <= n_calc;
                shift_rstn <= 1'b0;
            end
            if ((state_q == S_RST_HOLD) && ph_last) begin
                shift_rstn <= 1'b1;
            end
            if (state_q == S_DATA) begin
                shift_data_out <= sreg_q[CFG_WIDTH-1];
                capture_data   <= {capture_data[CFG_WIDTH-2:0], shift_data_in};
                bit_cnt_q      <= bit_cnt_q + 1'b1;
                if (widx_q == W_LAST) begin
                    // Word boundary: broadcast restarts the word, others feed zeros.
                    widx_q <= '0;
                    sreg_q <= (mode_q == MODE_BCAST) ? word_q
                                                     : {sreg_q[CFG_WIDTH-2:0], 1'b0};
                end else begin
                    widx_q <= widx_q + 1'b1;
                    sreg_q <= {sreg_q[CFG_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_gpio_pads_ctrl_pgen.sv
// Directed bench for gpio_pads_ctrl_pgen: write, broadcast, shift-only,
// rejection, abort and re-request, plus a HALF_PER=1 instance.
module tb_gpio_pads_ctrl_pgen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        shift_req;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_pad_no;
    logic [15:0] cfg_shift_data;
    logic        busy, shift_done, shift_err, shift_rstn, shift_clock, shift_load, shift_data_out;
    logic [15:0] capture_data;
    logic        shift_data_in;

    logic        req_f;
    logic        busy_f, done_f, err_f, rstn_f, sclk_f, load_f, dout_f;
    logic [15:0] cap_f;

    // Return-path models: 0 = tied low, 1 = one-cycle loopback, 2 = 32-bit chain.
    logic [1:0]   in_sel;
    logic         lb_q;
    logic [31:0]  chain;
    logic [31:0]  chain_init;
    logic         chain_ld;
    logic         mon_clr;
    logic [255:0] rec_bits;
    int           clk_cnt, load_cnt, load_cyc, done_cnt;
    logic         sclk_prev, load_prev;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gpio_pads_ctrl_pgen u_dut (
        .clk(clk), .rst_n(rst_n), .shift_req(shift_req), .cfg_mode(cfg_mode),
        .cfg_pad_no(cfg_pad_no), .cfg_shift_data(cfg_shift_data), .busy(busy),
        .shift_done(shift_done), .shift_err(shift_err), .capture_data(capture_data),
        .shift_rstn(shift_rstn), .shift_clock(shift_clock), .shift_load(shift_load),
        .shift_data_out(shift_data_out), .shift_data_in(shift_data_in)
    );

    gpio_pads_ctrl_pgen #(.HALF_PER(1)) u_fast (
        .clk(clk), .rst_n(rst_n), .shift_req(req_f), .cfg_mode(cfg_mode),
        .cfg_pad_no(cfg_pad_no), .cfg_shift_data(cfg_shift_data), .busy(busy_f),
        .shift_done(done_f), .shift_err(err_f), .capture_data(cap_f),
        .shift_rstn(rstn_f), .shift_clock(sclk_f), .shift_load(load_f),
        .shift_data_out(dout_f), .shift_data_in(1'b0)
    );

    assign shift_data_in = (in_sel == 2'd1) ? lb_q :
                           (in_sel == 2'd2) ? chain[31] : 1'b0;

    always @(posedge clk) lb_q <= shift_data_out;

    // Pin monitor: records bits at each serial clock rise, counts load/done pulses,
    // and shifts the chain model on the rising serial clock.
    always @(negedge clk) begin
        if (mon_clr) begin
            clk_cnt  <= 0;
            load_cnt <= 0;
            load_cyc <= 0;
            done_cnt <= 0;
            rec_bits <= '0;
        end else begin
            if (shift_clock && !sclk_prev) begin
                rec_bits[clk_cnt[7:0]] <= shift_data_out;
                clk_cnt <= clk_cnt + 1;
            end
            if (shift_load && !load_prev) load_cnt <= load_cnt + 1;
            if (shift_load) load_cyc <= load_cyc + 1;
            if (shift_done) done_cnt <= done_cnt + 1;
        end
        if (chain_ld) chain <= chain_init;
        else if (shift_clock && !sclk_prev) chain <= {chain[30:0], shift_data_out};
        sclk_prev <= shift_clock;
        load_prev <= shift_load;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bits recorded at serial clock rises, first recorded bit as MSB.
    function automatic logic [15:0] getword(input int start);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15-i] = rec_bits[start+i];
        return w;
    endfunction

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    // Issues one request and waits (bounded) for shift_done. lat counts cycles
    // from the accepting edge: 1 = the cycle right after acceptance.
    task automatic run_op(input logic [1:0] m, input logic [7:0] p, input logic [15:0] d,
                          input bit hold, output int lat, output logic err_d,
                          output logic busy_d, output logic busy_1, output logic rstn_1);
        @(negedge clk);
        cfg_mode = m; cfg_pad_no = p; cfg_shift_data = d; shift_req = 1'b1;
        @(posedge clk); #1;
        busy_1 = busy; rstn_1 = shift_rstn;
        if (!hold) shift_req = 1'b0;
        lat = 1;
        while (!shift_done && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        err_d = shift_err; busy_d = busy;
        shift_req = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, w, first, second;
        logic e_d, b_d, b_1, r_1, prev;
        rst_n = 1'b0; shift_req = 1'b0; req_f = 1'b0; cfg_mode = '0; cfg_pad_no = '0;
        cfg_shift_data = '0; in_sel = 2'd0; mon_clr = 1'b0; chain_ld = 1'b0; chain_init = '0;

        // Reset values
        repeat (3) @(posedge clk); #1;
        chk("reset_outputs", {busy, shift_done, shift_err, shift_rstn, shift_clock,
                              shift_load, shift_data_out, capture_data}, 64'h0);
        chk("reset_fast", {busy_f, done_f, err_f, rstn_f, sclk_f}, 64'h0);
        @(negedge clk); rst_n = 1'b1;

        // Write pad 0, 0xA5C3, loopback, request held for the whole operation
        in_sel = 2'd1;
        clear_mon();
        run_op(2'd0, 8'd0, 16'hA5C3, 1'b1, lat, e_d, b_d, b_1, r_1);
        chk("t1_latency", 64'(lat), 64'd217);
        chk("t1_busy_after_accept", b_1, 1);
        chk("t1_rstn_after_accept", r_1, 0);
        chk("t1_busy_at_done", b_d, 0);
        chk("t1_err_at_done", e_d, 0);
        repeat (5) @(posedge clk); #1;
        chk("t1_single_op_busy", busy, 0);
        chk("t1_done_count", 64'(done_cnt), 64'd1);
        chk("t1_clocks", 64'(clk_cnt), 64'd16);
        chk("t1_data", getword(0), 64'hA5C3);
        chk("t1_load_pulses", 64'(load_cnt), 64'd1);
        chk("t1_load_width", 64'(load_cyc), 64'd4);
        chk("t1_capture", capture_data, 64'h52E1);
        chk("t1_rstn_after", shift_rstn, 1);
        chk("t1_dout_holds", shift_data_out, 1);

        // Write pad 2, 0x8001, loopback
        clear_mon();
        run_op(2'd0, 8'd2, 16'h8001, 1'b0, lat, e_d, b_d, b_1, r_1);
        chk("t2_latency", 64'(lat), 64'd633);
        @(negedge clk);
        chk("t2_clocks", 64'(clk_cnt), 64'd48);
        chk("t2_word", getword(0), 64'h8001);
        chk("t2_tail_zero", {getword(16), getword(32)}, 64'h0);
        chk("t2_capture", capture_data, 64'h0000);
        chk("t2_load_pulses", 64'(load_cnt), 64'd1);

        // Broadcast pad 3, 0x1234, loopback
        clear_mon();
        run_op(2'd1, 8'd3, 16'h1234, 1'b0, lat, e_d, b_d, b_1, r_1);
        chk("t3_latency", 64'(lat), 64'd841);
        @(negedge clk);
        chk("t3_clocks", 64'(clk_cnt), 64'd64);
        chk("t3_words", {getword(0), getword(16), getword(32), getword(48)}, 64'h1234123412341234);
        chk("t3_load_pulses", 64'(load_cnt), 64'd1);
        chk("t3_capture", capture_data, 64'h091A);

        // Shift-only pad 1 through the chain model; the slot nearest
        // shift_data_out (bits 15:0) holds 0xBEEF and returns last.
        in_sel = 2'd2;
        chain_init = 32'h1357_BEEF;
        chain_ld = 1'b1;
        @(negedge clk);
        #1 chain_ld = 1'b0;
        clear_mon();
        run_op(2'd2, 8'd1, 16'h4C4C, 1'b0, lat, e_d, b_d, b_1, r_1);
        chk("t4_latency", 64'(lat), 64'd421);
        chk("t4_busy_at_done", b_d, 0);
        @(negedge clk);
        chk("t4_clocks", 64'(clk_cnt), 64'd32);
        chk("t4_no_load", 64'(load_cnt), 64'd0);
        chk("t4_capture", capture_data, 64'hBEEF);
        chk("t4_chain_after", chain, 64'h4C4C_0000);

        // Rejection: pad 64
        in_sel = 2'd0;
        clear_mon();
        run_op(2'd0, 8'd64, 16'hFFFF, 1'b0, lat, e_d, b_d, b_1, r_1);
        chk("t5_latency", 64'(lat), 64'd1);
        chk("t5_err", e_d, 1);
        chk("t5_busy", b_d, 1);
        @(posedge clk); #1;
        chk("t5_pulse_end", {shift_done, shift_err, busy}, 64'h0);
        chk("t5_no_clocks", 64'(clk_cnt), 64'd0);
        chk("t5_capture_holds", capture_data, 64'hBEEF);
        chk("t5_rstn_untouched", shift_rstn, 1);

        // Rejection: reserved mode, followed at once by a re-request
        clear_mon();
        run_op(2'd3, 8'd0, 16'h00FF, 1'b0, lat, e_d, b_d, b_1, r_1);
        chk("t6_latency", 64'(lat), 64'd1);
        chk("t6_err", e_d, 1);
        chk("t6_no_clocks_or_load", 64'(clk_cnt + load_cnt), 64'd0);
        clear_mon();
        cfg_mode = 2'd0; cfg_pad_no = 8'd0; cfg_shift_data = 16'hFFFF; shift_req = 1'b1;
        @(posedge clk); #1;
        chk("rereq_not_in_done", busy, 0);
        @(posedge clk); #1;
        chk("rereq_accepted", busy, 1);
        shift_req = 1'b0;

        // Abort in CLK_HI
        w = 0;
        while (!shift_clock && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk("abort_reached_clk_hi", shift_clock, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs_zero", {busy, shift_done, shift_err, shift_rstn, shift_clock,
                                   shift_load, shift_data_out, capture_data}, 64'h0);
        repeat (3) @(posedge clk); #1;
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("abort_stays_idle", {busy, shift_rstn}, 64'h0);

        // HALF_PER=1 instance: write pad 0
        @(negedge clk);
        cfg_mode = 2'd0; cfg_pad_no = 8'd0; cfg_shift_data = 16'h5A5A; req_f = 1'b1;
        @(posedge clk); #1;
        req_f = 1'b0;
        lat = 1; first = 0; second = 0; prev = sclk_f;
        while (!done_f && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (sclk_f && !prev) begin
                if (first == 0) first = lat;
                else if (second == 0) second = lat;
            end
            prev = sclk_f;
        end
        chk("fast_latency", 64'(lat), 64'd67);
        chk("fast_bit_period", 64'(second - first), 64'd4);
        chk("fast_done_flags", {err_f, busy_f}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
